// File: rtl/mpu_ip_sequencer.sv
// mpu_ip_sequencer: instruction pointer, commit strobe and stall control for mpu_execution
module mpu_ip_sequencer #(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    output logic [15:0] ip,
    output logic        commit,
    input  logic [15:0] ip_incr,
    input  logic        ip_load,
    input  logic [15:0] ip_data,
    input  logic        user_irq,
    output logic        irq,
    input  logic        irq_clear,
    input  logic        hm_start,
    output logic        hm_req,
    input  logic        hm_end,
    input  logic [63:0] hm_rdata,
    output logic [63:0] hm_data,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {IDLE, RUN, WAIT_HM, COMMIT_HM, WAIT_IRQ} state_t;

    state_t      state, state_nx;
    logic [15:0] ip_nx;

    assign ip_nx = ip_load ? ip_data : ip + ip_incr;

    // state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    // next-state selection; hm_start outranks user_irq in RUN
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = en ? RUN : IDLE;
            RUN:       state_nx = hm_start ? WAIT_HM : user_irq ? WAIT_IRQ : en ? RUN : IDLE;
            WAIT_HM:   state_nx = hm_end ? COMMIT_HM : WAIT_HM;
            COMMIT_HM: state_nx = user_irq ? WAIT_IRQ : en ? RUN : IDLE;
            WAIT_IRQ:  state_nx = irq_clear ? (en ? RUN : IDLE) : WAIT_IRQ;
            default:   state_nx = IDLE;
        endcase
    end

    // commit suppressed in RUN when a host read starts so stale data is never written
    always_comb begin
        commit = (state == RUN && !hm_start) || state == COMMIT_HM;
    end

    // ip, counter, interrupt flag, read request and read data latch
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ip      <= RESET_IP;
            irq     <= 1'b0;
            hm_req  <= 1'b0;
            hm_data <= 64'd0;
            retired <= 32'd0;
        end else begin
            hm_req <= state == RUN && hm_start;
            if (state == IDLE && en) ip <= RESET_IP;
            if (commit) begin
                ip      <= ip_nx;
                retired <= retired + 32'd1;
            end
            if (commit && user_irq) irq <= 1'b1;
            if (state == WAIT_IRQ && irq_clear) irq <= 1'b0;
            if (state == WAIT_HM && hm_end) hm_data <= hm_rdata;
        end
    end

endmodule

// File: tb/tb_mpu_ip_sequencer.sv
// tb_mpu_ip_sequencer: directed scoreboard bench for mpu_ip_sequencer
module tb_mpu_ip_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        en;
    logic [15:0] ip;
    logic        commit;
    logic [15:0] ip_incr;
    logic        ip_load;
    logic [15:0] ip_data;
    logic        user_irq;
    logic        irq;
    logic        irq_clear;
    logic        hm_start;
    logic        hm_req;
    logic        hm_end;
    logic [63:0] hm_rdata;
    logic [63:0] hm_data;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [15:0] ip;
        logic        commit;
        logic        irq;
        logic        req;
        logic [31:0] ret;
        logic [63:0] hm;
    } exp_t;

    exp_t q[$];

    localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEBABE;
    localparam logic [63:0] D2 = 64'h11112222_33334444;
    localparam logic [63:0] D3 = 64'hAAAA5555_AAAA5555;

    mpu_ip_sequencer #(.RESET_IP(16'h0000)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (en),
        .ip       (ip),
        .commit   (commit),
        .ip_incr  (ip_incr),
        .ip_load  (ip_load),
        .ip_data  (ip_data),
        .user_irq (user_irq),
        .irq      (irq),
        .irq_clear(irq_clear),
        .hm_start (hm_start),
        .hm_req   (hm_req),
        .hm_end   (hm_end),
        .hm_rdata (hm_rdata),
        .hm_data  (hm_data),
        .retired  (retired)
    );

    always #5 sys_clk = ~sys_clk;

    // pop one expectation at mid-cycle, compare every output, then move past the next edge
    task automatic sample();
        exp_t e;
        @(negedge sys_clk);
        e = q.pop_front();
        total++;
        assert (ip === e.ip) else begin bad++; $error("FAIL %s ip got=%h exp=%h", e.tag, ip, e.ip); end
        total++;
        assert (commit === e.commit) else begin bad++; $error("FAIL %s commit got=%b exp=%b", e.tag, commit, e.commit); end
        total++;
        assert (irq === e.irq) else begin bad++; $error("FAIL %s irq got=%b exp=%b", e.tag, irq, e.irq); end
        total++;
        assert (hm_req === e.req) else begin bad++; $error("FAIL %s hm_req got=%b exp=%b", e.tag, hm_req, e.req); end
        total++;
        assert (retired === e.ret) else begin bad++; $error("FAIL %s retired got=%0d exp=%0d", e.tag, retired, e.ret); end
        total++;
        assert (hm_data === e.hm) else begin bad++; $error("FAIL %s hm_data got=%h exp=%h", e.tag, hm_data, e.hm); end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic step(input string t, input logic [15:0] i, input logic c, input logic ir,
                        input logic r, input logic [31:0] rt, input logic [63:0] h);
        exp_t e;
        e.tag = t; e.ip = i; e.commit = c; e.irq = ir; e.req = r; e.ret = rt; e.hm = h;
        q.push_back(e);
        sample();
    endtask

    initial begin
        sys_rst = 1'b1; en = 1'b0; ip_incr = 16'd4; ip_load = 1'b0; ip_data = 16'd0;
        user_irq = 1'b0; irq_clear = 1'b0; hm_start = 1'b0; hm_end = 1'b0; hm_rdata = 64'd0;
        #1;
        step("reset", 16'h0000, 0, 0, 0, 0, 64'd0);
        sys_rst = 1'b0;
        step("idle", 16'h0000, 0, 0, 0, 0, 64'd0);
        en = 1'b1;
        step("idle_en", 16'h0000, 0, 0, 0, 0, 64'd0);
        step("lin0", 16'h0000, 1, 0, 0, 0, 64'd0);
        step("lin4", 16'h0004, 1, 0, 0, 1, 64'd0);
        step("lin8", 16'h0008, 1, 0, 0, 2, 64'd0);
        ip_load = 1'b1; ip_data = 16'hFFFC;
        step("lin12", 16'h000C, 1, 0, 0, 3, 64'd0);
        ip_load = 1'b0; ip_incr = 16'd8;
        step("wrap_src", 16'hFFFC, 1, 0, 0, 4, 64'd0);
        ip_load = 1'b1; ip_data = 16'h0100;
        step("wrap_dst", 16'h0004, 1, 0, 0, 5, 64'd0);
        ip_data = 16'h0010;
        step("branch", 16'h0100, 1, 0, 0, 6, 64'd0);
        ip_load = 1'b0; ip_incr = 16'd4; hm_start = 1'b1;
        step("mload_run", 16'h0010, 0, 0, 0, 7, 64'd0);
        step("mload_req", 16'h0010, 0, 0, 1, 7, 64'd0);
        step("mload_w2", 16'h0010, 0, 0, 0, 7, 64'd0);
        step("mload_w3", 16'h0010, 0, 0, 0, 7, 64'd0);
        step("mload_w4", 16'h0010, 0, 0, 0, 7, 64'd0);
        hm_end = 1'b1; hm_rdata = D1;
        step("mload_end", 16'h0010, 0, 0, 0, 7, 64'd0);
        hm_end = 1'b0; hm_rdata = 64'd0;
        step("mload_commit", 16'h0010, 1, 0, 0, 7, D1);
        hm_start = 1'b0; hm_end = 1'b1; hm_rdata = 64'h1234; ip_load = 1'b1; ip_data = 16'h0020;
        irq_clear = 1'b1;
        step("after_mload", 16'h0014, 1, 0, 0, 8, D1);
        hm_end = 1'b0; ip_load = 1'b0; irq_clear = 1'b0; user_irq = 1'b1; ip_incr = 16'd2;
        step("stray_ignored", 16'h0020, 1, 0, 0, 9, D1);
        user_irq = 1'b0;
        step("irq_wait1", 16'h0022, 0, 1, 0, 10, D1);
        step("irq_wait2", 16'h0022, 0, 1, 0, 10, D1);
        irq_clear = 1'b1;
        step("irq_clear", 16'h0022, 0, 1, 0, 10, D1);
        irq_clear = 1'b0;
        step("irq_resume", 16'h0022, 1, 0, 0, 10, D1);
        hm_start = 1'b1; user_irq = 1'b1;
        step("both_run", 16'h0024, 0, 0, 0, 11, D1);
        en = 1'b0;
        step("both_req", 16'h0024, 0, 0, 1, 11, D1);
        hm_end = 1'b1; hm_rdata = D2;
        step("both_end", 16'h0024, 0, 0, 0, 11, D1);
        hm_end = 1'b0;
        step("both_commit", 16'h0024, 1, 0, 0, 11, D2);
        hm_start = 1'b0; user_irq = 1'b0;
        step("both_irq", 16'h0026, 0, 1, 0, 12, D2);
        irq_clear = 1'b1;
        step("both_clear", 16'h0026, 0, 1, 0, 12, D2);
        irq_clear = 1'b0;
        step("stop_idle1", 16'h0026, 0, 0, 0, 12, D2);
        step("stop_idle2", 16'h0026, 0, 0, 0, 12, D2);
        en = 1'b1;
        step("restart", 16'h0026, 0, 0, 0, 12, D2);
        hm_start = 1'b1; en = 1'b0; ip_incr = 16'd4;
        step("restart_ip", 16'h0000, 0, 0, 0, 12, D2);
        hm_start = 1'b0;
        step("stop_req", 16'h0000, 0, 0, 1, 12, D2);
        hm_end = 1'b1; hm_rdata = D3;
        step("stop_end", 16'h0000, 0, 0, 0, 12, D2);
        hm_end = 1'b0;
        step("stop_commit", 16'h0000, 1, 0, 0, 12, D3);
        en = 1'b1;
        step("stop_idle", 16'h0004, 0, 0, 0, 13, D3);
        hm_start = 1'b1;
        step("rst_run", 16'h0000, 0, 0, 0, 13, D3);
        hm_start = 1'b0;
        sys_rst = 1'b1;
        step("rst_async", 16'h0000, 0, 0, 0, 0, 64'd0);
        sys_rst = 1'b0; en = 1'b0; hm_end = 1'b1; hm_rdata = D1;
        step("rst_late_end", 16'h0000, 0, 0, 0, 0, 64'd0);
        hm_end = 1'b0;
        step("rst_after", 16'h0000, 0, 0, 0, 0, 64'd0);
        total++;
        assert (q.size() == 0) else begin bad++; $error("FAIL queue_left got=%0d exp=0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpu_ip_sequencer.md
Name: mpu_ip_sequencer

Overview:
- Instruction-pointer and stall controller that sits directly in front of mpu_execution.
- Holds the MPU instruction pointer and consumes the execution stage's ip_incr/ip_load/ip_data, hm_start and user_irq outputs.
- Stalls the pipeline while a host-memory quad-word read or a user interrupt is outstanding.
- Gates all side effects through a single commit strobe; latches host read data for the MLOAD writeback.

Parameters:
- RESET_IP, 16'h0000, instruction pointer value after reset and after every restart from IDLE.

Ports:
- sys_clk  input  1  system clock
- sys_rst  input  1  asynchronous reset, active-high
- en  input  1  CPU run enable (level)
- ip  output  16  current instruction pointer to instruction memory/decode
- commit  output  1  current instruction's register write/side effects take effect this cycle
- ip_incr  input  16  instruction size from execution
- ip_load  input  1  branch taken
- ip_data  input  16  branch target
- user_irq  input  1  execution requests user interrupt
- irq  output  1  interrupt pending to CPU (level)
- irq_clear  input  1  CPU acknowledge, single-cycle pulse
- hm_start  input  1  execution requests host quad-word read
- hm_req  output  1  one-cycle read request to host bridge
- hm_end  input  1  host read data valid, single-cycle pulse
- hm_rdata  input  64  host read data
- hm_data  output  64  latched read data to execution
- retired  output  32  retired instruction counter

Behaviour:
- Reset (async, sys_rst=1):
  - state=IDLE, ip=RESET_IP, commit=0, irq=0, hm_req=0, hm_data=0, retired=0.
- States: IDLE, RUN, WAIT_HM, COMMIT_HM, WAIT_IRQ.
- IDLE:
  - commit=0.
  - en=1 -> RUN next cycle; ip reloaded with RESET_IP on that edge.
- RUN, each cycle one instruction at ip is evaluated:
  - If hm_start=1:
    - commit=0 (combinational; suppresses the stale-data write); ip holds.
    - hm_req=1 on the next cycle, for exactly 1 cycle.
    - -> WAIT_HM.
  - Else:
    - commit=1.
    - Next ip = ip_load ? ip_data : (ip + ip_incr) mod 2^16; wrap at 16'hFFFF is silent.
    - retired += 1.
    - If user_irq=1: irq<=1 and -> WAIT_IRQ; ip still advances, so a branch-on-irq instruction is honoured.
    - Else if en=0: -> IDLE.
    - Else stay in RUN.
- WAIT_HM:
  - commit=0; ip holds.
  - hm_end=1 -> hm_data<=hm_rdata and -> COMMIT_HM.
  - en deassertion is ignored until the read completes.
- COMMIT_HM:
  - Same instruction re-evaluated with hm_data stable.
  - commit=1; hm_start from execution is ignored in this state.
  - ip advances per the RUN rule; retired += 1.
  - -> RUN if en=1, else IDLE.
- WAIT_IRQ:
  - commit=0; irq=1.
  - irq_clear=1 -> irq<=0, then -> RUN if en=1, else IDLE.
- Ignored events:
  - irq_clear outside WAIT_IRQ.
  - hm_end outside WAIT_HM (hm_data unchanged).
- Simultaneous events:
  - hm_start and user_irq both set in RUN: hm_start wins.
  - The interrupt is taken in COMMIT_HM if user_irq is still asserted there; irq<=1 -> WAIT_IRQ.
- Counter:
  - retired wraps 32'hFFFFFFFF -> 0.
  - Increments only on commit cycles.
- Reset mid-operation:
  - Any state -> IDLE immediately.
  - Outstanding host read is abandoned; a later hm_end is ignored.
- Latency:
  - Sequential instruction: 1 cycle.
  - MLOAD: 3 cycles + host latency (RUN, hm_req cycle in WAIT_HM, ..., COMMIT_HM).

Test Plan:
- Linear run: reset, en=1, ip_incr=4, no loads -> ip 0,4,8,12 on consecutive RUN cycles; commit=1 each cycle; retired=3 after third commit.
- Branch and wrap: ip=16'hFFFC, ip_incr=8 -> ip=16'h0004. ip_load=1, ip_data=16'h0100 -> ip=16'h0100 next cycle.
- MLOAD: hm_start=1 at ip=0x10 -> commit=0 that cycle; hm_req pulses 1 cycle. Host returns hm_end with 0xDEADBEEF_CAFEBABE 5 cycles later -> hm_data equals it, commit=1 for one cycle, then ip=0x10+isize.
- Interrupt: user_irq=1 at ip=0x20, isize 2 -> irq=1, ip=0x22, commit=0 until irq_clear. irq_clear outside WAIT_IRQ has no effect.
- Stop and contention: en dropped during WAIT_HM -> read completes and commits, then IDLE. hm_start and user_irq asserted together -> read first, interrupt taken in COMMIT_HM.
- Async reset mid WAIT_HM -> ip=RESET_IP, irq=0, hm_data=0 before the next edge; a following hm_end is ignored.
